dice_roll_arbiter: RTL and testbench

- Shares one rng instance (3-bit output, free-running, advances every clk) among N requesters: processor MMIO port, game-turn FSM, etc.
- Round-robin grants a requester, then rejection-samples two fair dice in 1..6 from the rng stream and returns die values, sum and owner with a one-cycle done pulse.
- Sits between rng and the requesters; it is the only consumer of rng output.

---
 rtl/dice_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/dice_roll_arbiter.sv | 107 ++++++++++
 tb/tb_dice_roll_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared constants for the dice roll arbiter: FSM encoding, die range and
// the fallback faces used when the retry budget runs out.
package dice_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROLL0 = 2'd1;
    localparam logic [1:0] ST_ROLL1 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;

    localparam logic [2:0] FORCE_ON_ZERO  = 3'd1;
    localparam logic [2:0] FORCE_ON_SEVEN = 3'd2;

    // Maps a raw 3-bit sample to a legal face; in-range samples pass through.
    function automatic logic [2:0] map_die(input logic [2:0] s);
        if (s < DIE_MIN)
            return FORCE_ON_ZERO;
        else if (s > DIE_MAX)
            return FORCE_ON_SEVEN;
        else
            return s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_vld
);

    logic [2*N_REQ-1:0] rot;

    // Rotating the doubled vector puts requester ptr at bit 0.
    assign rot = {req, req} >> ptr;

    always_comb begin
        int k;
        k       = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        // Scan downward so the smallest offset from ptr wins last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = int'(ptr) + i;
                if (k >= N_REQ)
                    k = k - N_REQ;
                gnt_idx = ID_W'(k);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dice_roll_arbiter.sv
// Shares one free-running 3-bit rng among N requesters; rejection-samples two
// fair dice per granted roll and reports them with a one-cycle done pulse.
module dice_roll_arbiter
    import dice_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ID_W       = 1,
    parameter int SAMPLE_GAP = 2,
    parameter int MAX_RETRY  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       rng_rand,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic [ID_W-1:0]  owner,
    output logic [2:0]       die0,
    output logic [2:0]       die1,
    output logic [3:0]       sum
);

    localparam logic [3:0]      GAP_LAST  = 4'(SAMPLE_GAP - 1);
    localparam logic [3:0]      RETRY_LIM = 4'(MAX_RETRY);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);

    logic [1:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_vld;
    logic [3:0]      gap_cnt;
    logic [3:0]      retry_cnt;
    logic            rolling;
    logic            sample_en;
    logic            in_range;
    logic            accept;
    logic [2:0]      die_val;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign rolling   = (state == ST_ROLL0) || (state == ST_ROLL1);
    assign sample_en = rolling && (gap_cnt == GAP_LAST);
    assign in_range  = (rng_rand >= DIE_MIN) && (rng_rand <= DIE_MAX);
    // Out-of-range samples are only kept once the retry budget is spent.
    assign accept    = sample_en && (in_range || (retry_cnt == RETRY_LIM));
    assign die_val   = map_die(rng_rand);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        done = '0;
        if (state == ST_DONE)
            done[owner] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            die0      <= '0;
            die1      <= '0;
            sum       <= '0;
            rr_ptr    <= '0;
            gap_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        owner     <= gnt_idx;
                        gap_cnt   <= '0;
                        retry_cnt <= '0;
                        state     <= ST_ROLL0;
                    end
                end
                ST_ROLL0, ST_ROLL1: begin
                    gap_cnt <= (gap_cnt == GAP_LAST) ? 4'd0 : gap_cnt + 4'd1;
                    if (sample_en) begin
                        if (accept) begin
                            retry_cnt <= '0;
                            if (state == ST_ROLL0) begin
                                die0  <= die_val;
                                state <= ST_ROLL1;
                            end else begin
                                // sum is ready in the DONE cycle itself
                                die1  <= die_val;
                                sum   <= {1'b0, die0} + {1'b0, die_val};
                                state <= ST_DONE;
                            end
                        end else begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    rr_ptr <= (owner == LAST_ID) ? '0 : owner + ID_W'(1);
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Directed bench for dice_roll_arbiter with a stubbed rng driven from the bench.
module tb_dice_roll_arbiter;

    localparam int N_REQ      = 2;
    localparam int ID_W       = 1;
    localparam int SAMPLE_GAP = 2;
    localparam int MAX_RETRY  = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       rng_rand;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic             busy;
    logic [ID_W-1:0]  owner;
    logic [2:0]       die0;
    logic [2:0]       die1;
    logic [3:0]       sum;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [2:0] seq [$];
    bit         rand_mode = 1'b0;

    always #5 clk = ~clk;

    dice_roll_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .SAMPLE_GAP(SAMPLE_GAP), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rng_rand (rng_rand),
        .req      (req),
        .done     (done),
        .busy     (busy),
        .owner    (owner),
        .die0     (die0),
        .die1     (die1),
        .sum      (sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds seq (each entry held for one sample period) until done, bounded.
    task automatic wait_done(input string tag, output int cyc);
        int idx;
        cyc = 0;
        for (int t = 1; t <= 200; t++) begin
            if (rand_mode) begin
                rng_rand = 3'($urandom_range(7, 0));
            end else if (seq.size() > 0) begin
                idx = (t < 2) ? 0 : (t - 2) / 2;
                if (idx >= seq.size())
                    idx = seq.size() - 1;
                rng_rand = seq[idx];
            end
            tick();
            if (done != '0) begin
                cyc = t;
                break;
            end
        end
        check({tag, "_no_timeout"}, 32'(cyc != 0), 32'd1);
    endtask

    initial begin
        int         c;
        logic [7:0] seen0;
        logic [7:0] seen1;

        reset    = 1'b1;
        req      = '0;
        rng_rand = 3'd0;
        tick();
        tick();
        check("rst_done",  32'(done),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_die0",  32'(die0),  32'd0);
        check("rst_die1",  32'(die1),  32'd0);
        check("rst_sum",   32'(sum),   32'd0);
        reset = 1'b0;
        tick();

        // Single roll, every sample valid
        seq = '{3'd3};
        rng_rand = 3'd3;
        req = 2'b01;
        wait_done("single", c);
        check("single_lat",   32'(c),     32'd5);
        check("single_done",  32'(done),  32'b01);
        check("single_busy",  32'(busy),  32'd1);
        check("single_die0",  32'(die0),  32'd3);
        check("single_die1",  32'(die1),  32'd3);
        check("single_sum",   32'(sum),   32'd6);
        check("single_owner", 32'(owner), 32'd0);
        req = '0;
        tick();
        check("single_pulse_once", 32'(done), 32'd0);
        check("single_idle_busy",  32'(busy), 32'd0);

        // Two rejections on die0, then accepted samples
        seq = '{3'd0, 3'd7, 3'd5, 3'd2};
        req = 2'b10;
        wait_done("reject", c);
        check("reject_lat",   32'(c),     32'd9);
        check("reject_done",  32'(done),  32'b10);
        check("reject_die0",  32'(die0),  32'd5);
        check("reject_die1",  32'(die1),  32'd2);
        check("reject_sum",   32'(sum),   32'd7);
        check("reject_owner", 32'(owner), 32'd1);
        req = '0;
        tick();

        // Retry budget exhausted on both dice: 7 -> 2
        seq = '{3'd7};
        req = 2'b10;
        wait_done("forced", c);
        check("forced_lat",   32'(c),     32'd33);
        check("forced_die0",  32'(die0),  32'd2);
        check("forced_die1",  32'(die1),  32'd2);
        check("forced_sum",   32'(sum),   32'd4);
        check("forced_owner", 32'(owner), 32'd1);
        req = '0;
        tick();

        // Both requesting continuously: strict alternation from pointer 0
        seq = '{3'd6};
        req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            wait_done("rr", c);
            check("rr_lat",   32'(c),     (k == 0) ? 32'd5 : 32'd6);
            check("rr_done",  32'(done),  (k % 2 == 0) ? 32'b01 : 32'b10);
            check("rr_owner", 32'(owner), 32'(k % 2));
            check("rr_sum",   32'(sum),   32'd12);
        end
        req = '0;
        tick();

        // Reset in ROLL1 with die0 already latched; pointer is 1 beforehand
        rng_rand = 3'd4;
        req = 2'b01;
        tick();
        tick();
        tick();
        check("mid_die0", 32'(die0), 32'd4);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_die0",  32'(die0),  32'd0);
        check("mid_rst_die1",  32'(die1),  32'd0);
        check("mid_rst_sum",   32'(sum),   32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_busy",  32'(busy),  32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_rst_no_done", 32'(done), 32'd0);
        end
        reset = 1'b0;
        seq = '{3'd4};
        req = 2'b11;
        wait_done("post_rst", c);
        check("post_rst_lat",   32'(c),     32'd5);
        check("post_rst_owner", 32'(owner), 32'd0);
        check("post_rst_sum",   32'(sum),   32'd8);
        req = '0;
        tick();

        // Long run on random samples
        rand_mode = 1'b1;
        seen0 = '0;
        seen1 = '0;
        for (int k = 0; k < 1000; k++) begin
            req = 2'b01;
            wait_done("long", c);
            req = '0;
            check("long_done",   32'(done), 32'b01);
            check("long_die0_ok", 32'((die0 >= 3'd1) && (die0 <= 3'd6)), 32'd1);
            check("long_die1_ok", 32'((die1 >= 3'd1) && (die1 <= 3'd6)), 32'd1);
            check("long_sum",    32'(sum), 32'(die0) + 32'(die1));
            seen0[die0] = 1'b1;
            seen1[die1] = 1'b1;
            tick();
        end
        check("long_cov_die0", 32'(seen0), 32'h7e);
        check("long_cov_die1", 32'(seen1), 32'h7e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
